// File: rtl/stopwatch_up_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_up_pkg
// Shared definitions for the stopwatch / countdown-timer pair:
//   - sw_state_t   : 2-bit FSM encoding IDLE/RUN/PAUSE/DONE
//   - SEG_0..SEG_9 : active-low 7-segment codes {a,b,c,d,e,f,g,dp}, dp off
//   - SEG_BLANK    : all segments off
//   - seg_decode() : BCD digit to segment code (non-BCD input shows blank)
//   - bcd_inc()    : increment a 4-digit packed BCD value with digit carries
// -----------------------------------------------------------------------------
package stopwatch_up_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_t;

    localparam logic [7:0] SEG_0     = 8'b0000_0011;
    localparam logic [7:0] SEG_1     = 8'b1001_1111;
    localparam logic [7:0] SEG_2     = 8'b0010_0101;
    localparam logic [7:0] SEG_3     = 8'b0000_1101;
    localparam logic [7:0] SEG_4     = 8'b1001_1001;
    localparam logic [7:0] SEG_5     = 8'b0100_1001;
    localparam logic [7:0] SEG_6     = 8'b0100_0001;
    localparam logic [7:0] SEG_7     = 8'b0001_1111;
    localparam logic [7:0] SEG_8     = 8'b0000_0001;
    localparam logic [7:0] SEG_9     = 8'b0000_1001;
    localparam logic [7:0] SEG_BLANK = 8'b1111_1111;

    localparam logic [15:0] COUNT_MAX = 16'h9999;

    function automatic logic [7:0] seg_decode(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Ripple the carry from the tenths digit upward; a digit at 9 rolls to 0.
    function automatic logic [15:0] bcd_inc(input logic [15:0] value);
        logic [15:0] res;
        logic        carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                    carry         = 1'b1;
                end else begin
                    res[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                res[4*i +: 4] = value[4*i +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/stopwatch_up_button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises a raw pushbutton, debounces it on a slow sample enable and
// emits a one-clock pulse on each accepted press.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (all state to 0)
//   i_sample : one-clock sample enable
//   i_raw    : raw button level, active high, asynchronous
//   o_pulse  : one clock high on the debounced rising edge
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEB_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sample,
    input  logic i_raw,
    output logic o_pulse
);

    logic [1:0]         r_sync;
    logic [DEB_LEN-1:0] r_hist;
    logic               r_deb;
    logic               r_deb_q;
    logic [DEB_LEN-1:0] w_hist_next;

    // Newest sample enters at bit 0; a level is accepted once the whole window agrees.
    assign w_hist_next = {r_hist[DEB_LEN-2:0], r_sync[1]};

    // Synchroniser, sample history, debounced level and its delayed copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= 2'b00;
            r_hist  <= {DEB_LEN{1'b0}};
            r_deb   <= 1'b0;
            r_deb_q <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_deb_q <= r_deb;
            if (i_sample) begin
                r_hist <= w_hist_next;
                if (&w_hist_next) begin
                    r_deb <= 1'b1;
                end else if (~|w_hist_next) begin
                    r_deb <= 1'b0;
                end else begin
                    r_deb <= r_deb;
                end
            end else begin
                r_hist <= r_hist;
                r_deb  <= r_deb;
            end
        end
    end

    assign o_pulse = r_deb & ~r_deb_q;

endmodule

// File: rtl/stopwatch_up.sv
// -----------------------------------------------------------------------------
// stopwatch_up
// Count-up BCD stopwatch 000.0 .. 999.9 s with start/pause and lap/clear
// buttons, a 4-digit multiplexed 7-segment display and a 16-LED done flag.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   start   : raw start/pause button, active high
//   lap     : raw lap/clear button, active high
//   DIGIT   : anode select, active low (combinational from registers)
//   DISPLAY : {a,b,c,d,e,f,g,dp}, active low (combinational from registers)
//   led     : 16'hFFFF while saturated (DONE), else 0 (registered)
// -----------------------------------------------------------------------------
module stopwatch_up
    import stopwatch_up_pkg::*;
#(
    parameter int TICK_DIV    = 10_000_000,
    parameter int SAMPLE_BITS = 16,
    parameter int DEB_LEN     = 4,
    parameter int SCAN_BITS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        lap,
    output logic [3:0]  DIGIT,
    output logic [7:0]  DISPLAY,
    output logic [15:0] led
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    sw_state_t          r_state;
    sw_state_t          w_state_next;
    logic [15:0]        r_count;
    logic [15:0]        w_count_next;
    logic [15:0]        r_disp;
    logic [15:0]        w_disp_next;
    logic               r_frozen;
    logic               w_frozen_next;
    logic [PRE_W-1:0]   r_presc;
    logic [PRE_W-1:0]   w_presc_next;
    logic [15:0]        r_led;
    logic [SCAN_BITS-1:0] r_scan;

    logic               w_sample;
    logic               w_start_p;
    logic               w_lap_p;
    logic               w_tick;
    logic [15:0]        w_value;
    logic [1:0]         w_sel;

    // Debounce sampling piggybacks on the scan counter: one clock in 2**SAMPLE_BITS.
    assign w_sample = &r_scan[SAMPLE_BITS-1:0];

    button_conditioner #(.DEB_LEN(DEB_LEN)) u_start_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (w_sample),
        .i_raw    (start),
        .o_pulse  (w_start_p)
    );

    button_conditioner #(.DEB_LEN(DEB_LEN)) u_lap_cond (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_sample (w_sample),
        .i_raw    (lap),
        .o_pulse  (w_lap_p)
    );

    // Free-running display scan counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan <= {SCAN_BITS{1'b0}};
        end else begin
            r_scan <= r_scan + SCAN_BITS'(1);
        end
    end

    // Next-state logic: FSM, prescaler, BCD count and lap freeze
    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_disp_next   = r_disp;
        w_frozen_next = r_frozen;
        w_presc_next  = r_presc;
        w_tick        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start_p) begin
                    w_state_next = ST_RUN;
                    w_presc_next = {PRE_W{1'b0}};
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (r_presc == PRE_LAST) begin
                    w_tick       = 1'b1;
                    w_presc_next = {PRE_W{1'b0}};
                end else begin
                    w_presc_next = r_presc + PRE_W'(1);
                end
                // Saturation takes precedence over a start pulse in the same clock.
                if (w_tick && (r_count == COUNT_MAX)) begin
                    w_state_next  = ST_DONE;
                    w_frozen_next = 1'b0;
                end else begin
                    if (w_tick) begin
                        w_count_next = bcd_inc(r_count);
                    end else begin
                        w_count_next = r_count;
                    end
                    if (w_start_p) begin
                        w_state_next = ST_PAUSE;
                    end else if (w_lap_p) begin
                        w_frozen_next = ~r_frozen;
                        // Capture the value currently shown, before any same-clock tick.
                        if (!r_frozen) begin
                            w_disp_next = r_count;
                        end else begin
                            w_disp_next = r_disp;
                        end
                    end else begin
                        w_state_next = ST_RUN;
                    end
                end
            end
            ST_PAUSE: begin
                // Prescaler is left untouched so the partial tenth resumes.
                if (w_start_p) begin
                    w_state_next = ST_RUN;
                end else if (w_lap_p) begin
                    w_state_next  = ST_IDLE;
                    w_count_next  = 16'h0000;
                    w_frozen_next = 1'b0;
                end else begin
                    w_state_next = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (w_lap_p) begin
                    w_state_next  = ST_IDLE;
                    w_count_next  = 16'h0000;
                    w_frozen_next = 1'b0;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, count, freeze, prescaler and LED registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_count  <= 16'h0000;
            r_disp   <= 16'h0000;
            r_frozen <= 1'b0;
            r_presc  <= {PRE_W{1'b0}};
            r_led    <= 16'h0000;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_disp   <= w_disp_next;
            r_frozen <= w_frozen_next;
            r_presc  <= w_presc_next;
            r_led    <= (w_state_next == ST_DONE) ? 16'hFFFF : 16'h0000;
        end
    end

    assign led     = r_led;
    assign w_value = r_frozen ? r_disp : r_count;
    assign w_sel   = r_scan[SCAN_BITS-1 -: 2];

    // Digit multiplexer and segment decode with leading-zero blanking
    always_comb begin
        DIGIT   = 4'b1110;
        DISPLAY = SEG_BLANK;
        case (w_sel)
            2'b00: begin
                DIGIT   = 4'b1110;
                DISPLAY = seg_decode(w_value[3:0]);
            end
            2'b01: begin
                DIGIT   = 4'b1101;
                DISPLAY = seg_decode(w_value[7:4]) & 8'b1111_1110;
            end
            2'b10: begin
                DIGIT = 4'b1011;
                if ((w_value[15:12] == 4'd0) && (w_value[11:8] == 4'd0)) begin
                    DISPLAY = SEG_BLANK;
                end else begin
                    DISPLAY = seg_decode(w_value[11:8]);
                end
            end
            2'b11: begin
                DIGIT = 4'b0111;
                if (w_value[15:12] == 4'd0) begin
                    DISPLAY = SEG_BLANK;
                end else begin
                    DISPLAY = seg_decode(w_value[15:12]);
                end
            end
            default: begin
                DIGIT   = 4'b1111;
                DISPLAY = SEG_BLANK;
            end
        endcase
    end

endmodule

// File: tb/tb_stopwatch_up.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_up
// Randomised bench for stopwatch_up with small simulation parameters.
// The stimulus process advances an integer-level reference model each clock
// and queues the expected {DIGIT, DISPLAY, led}; a monitor pops and compares
// on every falling edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_up;

    localparam int TICK_DIV    = 4;
    localparam int SAMPLE_BITS = 2;
    localparam int DEB_LEN     = 4;
    localparam int SCAN_BITS   = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    localparam logic [27:0] RESET_EXP = {4'b1110, 8'b0000_0011, 16'h0000};

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        lap;
    logic [3:0]  DIGIT;
    logic [7:0]  DISPLAY;
    logic [15:0] led;

    logic [7:0] seg_tab [10] = '{8'b0000_0011, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                                 8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111,
                                 8'b0000_0001, 8'b0000_1001};

    logic [27:0] exp_q [$];
    int total;
    int bad;

    // Reference model state
    int m_clks;          // clock edges since reset release
    int m_state;
    int m_pre;           // clocks spent in the current tenth
    int m_count;         // elapsed tenths, 0..9999
    int m_disp;
    bit m_frozen;
    bit b_sync1 [2];
    bit b_sync2 [2];
    bit b_deb   [2];
    bit b_deb_q [2];
    int b_ones  [2];
    int b_zeros [2];

    stopwatch_up #(
        .TICK_DIV    (TICK_DIV),
        .SAMPLE_BITS (SAMPLE_BITS),
        .DEB_LEN     (DEB_LEN),
        .SCAN_BITS   (SCAN_BITS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .lap     (lap),
        .DIGIT   (DIGIT),
        .DISPLAY (DISPLAY),
        .led     (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_clks   = 0;
        m_state  = S_IDLE;
        m_pre    = 0;
        m_count  = 0;
        m_disp   = 0;
        m_frozen = 1'b0;
        for (int b = 0; b < 2; b++) begin
            b_sync1[b] = 1'b0;
            b_sync2[b] = 1'b0;
            b_deb[b]   = 1'b0;
            b_deb_q[b] = 1'b0;
            b_ones[b]  = 0;
            b_zeros[b] = DEB_LEN;
        end
    endfunction

    // Advance the model by one clock given the raw levels held before the edge.
    function automatic void model_step(input bit s_raw, input bit l_raw);
        bit raw [2];
        bit ps;
        bit pl;
        bit sample;
        bit tick;
        int shown;
        raw[0] = s_raw;
        raw[1] = l_raw;
        ps     = b_deb[0] && !b_deb_q[0];
        pl     = b_deb[1] && !b_deb_q[1];
        sample = (m_clks % (1 << SAMPLE_BITS)) == ((1 << SAMPLE_BITS) - 1);
        for (int b = 0; b < 2; b++) begin
            b_deb_q[b] = b_deb[b];
            if (sample) begin
                if (b_sync2[b]) begin
                    b_ones[b]++;
                    b_zeros[b] = 0;
                end else begin
                    b_zeros[b]++;
                    b_ones[b] = 0;
                end
                if (b_ones[b] >= DEB_LEN) b_deb[b] = 1'b1;
                else if (b_zeros[b] >= DEB_LEN) b_deb[b] = 1'b0;
            end
            b_sync2[b] = b_sync1[b];
            b_sync1[b] = raw[b];
        end
        case (m_state)
            S_IDLE: begin
                if (ps) begin
                    m_state = S_RUN;
                    m_pre   = 0;
                end
            end
            S_RUN: begin
                tick  = (m_pre == TICK_DIV - 1);
                m_pre = (m_pre + 1) % TICK_DIV;
                if (tick && m_count == 9999) begin
                    m_state  = S_DONE;
                    m_frozen = 1'b0;
                end else begin
                    shown = m_count;
                    if (tick) m_count = m_count + 1;
                    if (ps) begin
                        m_state = S_PAUSE;
                    end else if (pl) begin
                        if (!m_frozen) m_disp = shown;
                        m_frozen = !m_frozen;
                    end
                end
            end
            S_PAUSE: begin
                if (ps) begin
                    m_state = S_RUN;
                end else if (pl) begin
                    m_state  = S_IDLE;
                    m_count  = 0;
                    m_frozen = 1'b0;
                end
            end
            default: begin
                if (pl) begin
                    m_state  = S_IDLE;
                    m_count  = 0;
                    m_frozen = 1'b0;
                end
            end
        endcase
        m_clks++;
    endfunction

    function automatic logic [27:0] model_out();
        int v;
        int sel;
        logic [3:0] dg;
        logic [7:0] sg;
        v   = m_frozen ? m_disp : m_count;
        sel = (m_clks % (1 << SCAN_BITS)) / (1 << (SCAN_BITS - 2));
        case (sel)
            0: begin dg = 4'b1110; sg = seg_tab[v % 10]; end
            1: begin dg = 4'b1101; sg = seg_tab[(v / 10) % 10] & 8'hFE; end
            2: begin dg = 4'b1011; sg = (v < 100) ? 8'hFF : seg_tab[(v / 100) % 10]; end
            default: begin dg = 4'b0111; sg = (v < 1000) ? 8'hFF : seg_tab[v / 1000]; end
        endcase
        return {dg, sg, (m_state == S_DONE) ? 16'hFFFF : 16'h0000};
    endfunction

    function automatic void check(input logic [27:0] exp);
        total++;
        if ({DIGIT, DISPLAY} !== exp[27:16]) begin
            bad++;
            $display("FAIL disp t=%0t got DIGIT=%b DISPLAY=%b want DIGIT=%b DISPLAY=%b",
                     $time, DIGIT, DISPLAY, exp[27:24], exp[23:16]);
        end
        total++;
        if (led !== exp[15:0]) begin
            bad++;
            $display("FAIL led t=%0t got %h want %h", $time, led, exp[15:0]);
        end
    endfunction

    // Monitor: compare DUT outputs against queued expectations on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) check(exp_q.pop_front());
        end
    end

    // One clock: drive raw levels, step the model at the edge, queue the expectation.
    task automatic cyc(input bit s, input bit l);
        start = s;
        lap   = l;
        @(posedge clk);
        if (rst_n) begin
            model_step(s, l);
            exp_q.push_back(model_out());
        end else begin
            exp_q.push_back(RESET_EXP);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic press(input int btn, input int bounce, input int hold, input int gap);
        bit v;
        for (int i = 0; i < bounce; i++) begin
            v = 1'($urandom_range(0, 1));
            cyc((btn == 0) ? v : 1'b0, (btn == 1) ? v : 1'b0);
        end
        repeat (hold) cyc(btn == 0, btn == 1);
        repeat (gap) cyc(1'b0, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        lap   = 1'b0;
        model_reset();
        #1;
        repeat (3) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (5) cyc(1'b0, 1'b0);

        // Start toggled every clock for 40 clocks, then held: one pulse only.
        for (int i = 0; i < 40; i++) cyc(i[0], 1'b0);
        repeat (30) cyc(1'b1, 1'b0);
        repeat (200) cyc(1'b0, 1'b0);

        // Random presses of start/lap with bounce, hold and gap lengths.
        for (int n = 0; n < 40; n++) begin
            press(int'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
                  int'($urandom_range(20, 30)), int'($urandom_range(20, 150)));
        end

        // Asynchronous reset mid-run while start is held down.
        repeat (3) cyc(1'b1, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(RESET_EXP);
        repeat (3) cyc(1'b1, 1'b0);
        rst_n = 1'b1;
        repeat (30) cyc(1'b1, 1'b0);

        // Run through every carry up to saturation.
        repeat (40100) cyc(1'b0, 1'b0);
        press(0, 0, 25, 30);
        press(1, 0, 25, 30);
        press(0, 0, 25, 40);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
